// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the PC register and IF/ID: issues in-order
// fetches, buffers returned words with their PCs and presents them to decode.
module if_fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] ADDR_LO = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI = 32'h0000_4ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_adv,
    input  logic        flush,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [4:0]  id_exc,
    input  logic        id_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef struct packed {
        logic        filled;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } entry_t;

    entry_t        q       [DEPTH];
    // Queue slot of every outstanding request, oldest first; responses return in order.
    logic [PW-1:0] req_idx [DEPTH];

    logic [PW-1:0] head, tail, req_rd, req_wr;
    logic [CW-1:0] count, pend_cnt, drop_cnt;

    logic          bad_pc, space;
    logic          alloc_good, alloc_bad, alloc;
    logic          rsp_drop, rsp_fill, pop;
    logic [CW:0]   occ, flush_drop;
    entry_t        head_e;

    // Allocation and handshake decisions
    always_comb begin
        bad_pc     = (pc[1:0] != 2'b00) | (pc < ADDR_LO) | (pc > ADDR_HI);
        occ        = (CW+1)'(count) + (CW+1)'(drop_cnt);
        space      = reset & ~flush & (occ < (CW+1)'(DEPTH));
        alloc_good = space & ~bad_pc & im_gnt;
        alloc_bad  = space & bad_pc;
        alloc      = alloc_good | alloc_bad;
        im_req     = space & ~bad_pc;
        im_addr    = pc;
        pc_adv     = alloc;

        rsp_drop   = im_rvalid & ~flush & (drop_cnt != '0);
        rsp_fill   = im_rvalid & ~flush & (drop_cnt == '0) & (pend_cnt != '0);

        // Stale responses owed after a flush; a response in the flush cycle is one of them.
        flush_drop = (CW+1)'(drop_cnt) + (CW+1)'(pend_cnt);
        if (im_rvalid && (flush_drop != '0)) begin
            flush_drop = flush_drop - (CW+1)'(1);
        end
    end

    // Head presentation
    always_comb begin
        head_e   = q[head];
        id_valid = (count != '0) & head_e.filled;
        id_instr = id_valid ? head_e.instr : 32'd0;
        id_pc    = id_valid ? head_e.pc    : 32'd0;
        id_exc   = id_valid ? head_e.exc   : EXC_NONE;
        pop      = id_valid & id_ready & ~flush;
    end

    // Queue, request ring and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            req_rd   <= '0;
            req_wr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i]       <= '0;
                req_idx[i] <= '0;
            end
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            req_rd   <= '0;
            req_wr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= CW'(flush_drop);
        end else begin
            if (alloc) begin
                q[tail].filled <= alloc_bad;
                q[tail].pc     <= pc;
                q[tail].instr  <= 32'd0;
                q[tail].exc    <= alloc_bad ? EXC_ADEL : EXC_NONE;
                tail           <= tail + PW'(1);
            end
            if (alloc_good) begin
                req_idx[req_wr] <= tail;
                req_wr          <= req_wr + PW'(1);
            end
            if (rsp_fill) begin
                q[req_idx[req_rd]].filled <= 1'b1;
                q[req_idx[req_rd]].instr  <= im_rdata;
                q[req_idx[req_rd]].exc    <= EXC_NONE;
                req_rd                    <= req_rd + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            count    <= count + CW'(alloc) - CW'(pop);
            pend_cnt <= pend_cnt + CW'(alloc_good) - CW'(rsp_fill);
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: an in-order memory with variable latency
// and a queue-based reference model of fetch, fill, pop, flush and AdEL rules.
module tb_if_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] LO    = 32'h0000_3000;
    localparam logic [31:0] HI    = 32'h0000_4ffc;

    logic        clk, reset, flush, pc_adv, im_req, im_gnt, im_rvalid;
    logic        id_valid, id_ready;
    logic [31:0] pc, im_addr, im_rdata, id_instr, id_pc;
    logic [4:0]  id_exc;

    if_fetch_queue #(.DEPTH(DEPTH), .ADDR_LO(LO), .ADDR_HI(HI)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_adv(pc_adv), .flush(flush),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_exc(id_exc), .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          filled;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } ment_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ment_t mq[$];
    mreq_t mem[$];
    int    drop, cyc, last_due;
    int    tests, fails;
    int    lat_max, gnt_pct, ready_pct, flush_pct, bad_pct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] rand_good();
        return LO + (32'($urandom_range(0, 32'h7ff)) << 2);
    endfunction

    function automatic logic [31:0] rand_bad();
        case ($urandom_range(0, 2))
            0:       return rand_good() | 32'd2;
            1:       return 32'h0000_5000;
            default: return 32'h0000_2ffc;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_id_instr"}, id_instr, 32'd0);
        chk({tag, "_id_pc"},    id_pc, 32'd0);
        chk({tag, "_id_exc"},   32'(id_exc), 32'd0);
        chk({tag, "_im_req"},   32'(im_req), 32'd0);
        chk({tag, "_pc_adv"},   32'(pc_adv), 32'd0);
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step();
        logic        bad, space, exp_req, exp_adv, exp_valid;
        logic [31:0] npc;
        int          pend, s, due;
        ment_t       e;

        flush    = ($urandom_range(0, 99) < flush_pct);
        im_gnt   = ($urandom_range(0, 99) < gnt_pct);
        id_ready = ($urandom_range(0, 99) < ready_pct);
        if (mem.size() > 0 && mem[0].due <= cyc) begin
            im_rvalid = 1'b1;
            im_rdata  = mem_word(mem[0].addr);
            void'(mem.pop_front());
        end else begin
            im_rvalid = 1'b0;
            im_rdata  = $urandom;
        end
        #2;

        bad       = (pc[1:0] != 2'b00) || (pc < LO) || (pc > HI);
        space     = ((mq.size() + drop) < DEPTH) && !flush;
        exp_req   = space && !bad;
        exp_adv   = space && (bad || im_gnt);
        exp_valid = (mq.size() > 0) && mq[0].filled;

        chk("im_req", 32'(im_req), 32'(exp_req));
        chk("pc_adv", 32'(pc_adv), 32'(exp_adv));
        if (exp_req) chk("im_addr", im_addr, pc);
        chk("id_valid", 32'(id_valid), 32'(exp_valid));
        chk("id_pc",    id_pc,    exp_valid ? mq[0].pc    : 32'd0);
        chk("id_instr", id_instr, exp_valid ? mq[0].instr : 32'd0);
        chk("id_exc",   32'(id_exc), exp_valid ? 32'(mq[0].exc) : 32'd0);

        if (exp_req && im_gnt) begin
            due = cyc + $urandom_range(1, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem.push_back('{addr: pc, due: due});
        end

        if (flush) begin
            pend = 0;
            foreach (mq[i]) if (!mq[i].filled) pend++;
            s = drop + pend;
            if (im_rvalid && s > 0) s--;
            drop = s;
            mq.delete();
        end else begin
            if (exp_valid && id_ready) void'(mq.pop_front());
            if (im_rvalid) begin
                if (drop > 0) drop--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].instr  = im_rdata;
                            mq[i].exc    = 5'd0;
                            break;
                        end
                    end
                end
            end
            if (exp_adv) begin
                e.filled = bad;
                e.pc     = pc;
                e.instr  = 32'd0;
                e.exc    = bad ? 5'd4 : 5'd0;
                mq.push_back(e);
            end
        end

        if (flush) npc = ($urandom_range(0, 99) < bad_pct) ? rand_bad() : rand_good();
        else if (exp_adv) begin
            if (bad)                                    npc = rand_good();
            else if ($urandom_range(0, 99) < bad_pct)   npc = rand_bad();
            else if (pc + 32'd4 > HI)                   npc = LO;
            else                                        npc = pc + 32'd4;
        end else npc = pc;

        @(posedge clk);
        #1;
        pc = npc;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input int lat, input int g, input int r, input int f, input int b);
        lat_max = lat; gnt_pct = g; ready_pct = r; flush_pct = f; bad_pct = b;
    endtask

    initial begin
        tests = 0; fails = 0; drop = 0; cyc = 0; last_due = 0;
        reset = 1'b1; pc = LO; flush = 1'b0; im_gnt = 1'b0;
        im_rvalid = 1'b0; im_rdata = 32'd0; id_ready = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Streaming with single-cycle memory
        knobs(1, 100, 100, 0, 0);
        run(20);
        // Decode stall fills the queue, then drains
        knobs(1, 100, 0, 0, 0);
        run(10);
        knobs(1, 100, 100, 0, 0);
        run(10);
        // Address errors in the stream
        knobs(1, 100, 50, 0, 40);
        run(40);
        // Slow memory with flushes
        knobs(3, 70, 70, 8, 8);
        run(800);

        // Asynchronous reset mid-stream with a full queue
        knobs(1, 100, 0, 0, 0);
        run(6);
        reset = 1'b0; flush = 1'b0; im_rvalid = 1'b0;
        #1 check_reset_outputs("mid");
        mq.delete(); mem.delete(); drop = 0; last_due = cyc;
        @(posedge clk);
        #1 reset = 1'b1;
        pc = 32'h0000_3400;
        cyc++;
        knobs(1, 100, 100, 0, 0);
        run(20);

        // Long latency, frequent flushes
        knobs(4, 80, 60, 15, 5);
        run(600);
        knobs(2, 100, 100, 0, 0);
        run(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the PC register and the IF/ID boundary of the pipelined MIPS core. It takes the current PC and issues in-order requests to instruction memory over a grant/valid handshake. It buffers returned instructions with their PCs and presents them to the decode stage under valid/ready. It tells the PC stage when it may advance, raises AdEL for illegal fetch addresses without touching memory, and on IRQ/eret discards everything in flight.

## Interface
- DEPTH, 4: queue entries (power of 2, ≥2); also bounds outstanding memory requests
- ADDR_LO, 32'h0000_3000: lowest legal fetch address
- ADDR_HI, 32'h0000_4ffc: highest legal fetch address
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- pc  in  32  current PC from the PC register
- pc_adv  out  1  PC may load NPC this cycle; PC stage stall = ~pc_adv
- flush  in  1  IRQ | eret_M; discard queue and in-flight responses
- im_req  out  1  fetch request valid
- im_addr  out  32  fetch address (= pc)
- im_gnt  in  1  memory accepts request this cycle
- im_rvalid  in  1  response valid; responses in request order, ≥1 cycle after grant
- im_rdata  in  32  response instruction word
- id_valid  out  1  head entry holds a complete instruction
- id_instr  out  32  head instruction (0 when empty or exception)
- id_pc  out  32  head PC (0 when empty)
- id_exc  out  5  ExcCode: 0 = none, 4 = AdEL
- id_ready  in  1  decode consumes head when id_valid & id_ready

## Operation
- State: circular queue of DEPTH entries {filled, pc, instr, exc}, head/tail pointers, count (0..DEPTH), pend_cnt (allocated-unfilled entries), drop_cnt (stale responses still owed).
- bad_pc = pc[1:0]≠0 | pc<ADDR_LO | pc>ADDR_HI.
- space = (count + drop_cnt < DEPTH) & ~flush & reset high. Pops in the same cycle do not create space.
- Good PC: im_req = space. On im_req & im_gnt, allocate tail entry {filled=0, pc}; pc_adv = 1.
- Bad PC: im_req = 0. If space, allocate tail entry {filled=1, pc, instr=0, exc=4}; pc_adv = 1.
- Otherwise pc_adv = 0.
- Response: if drop_cnt>0, discard and decrement drop_cnt. Otherwise fill the oldest unfilled entry with im_rdata, exc=0.
- Head output: id_valid = count>0 & head.filled. id_* come from the head, zeros when id_valid=0.
- Pop on id_valid & id_ready.
- Flush: count, pointers and pend_cnt go to 0. Set drop_cnt ← drop_cnt + pend_cnt − (im_rvalid this cycle ? 1 : 0). No allocation and no pop that cycle. pc_adv=0 because the PC register handles IRQ/eret by priority.
- A response arriving in the flush cycle is stale and is discarded.
- Simultaneous allocate, fill and pop in one cycle are all legal. Count changes by allocations minus pops.
- im_rvalid with pend_cnt=0 and drop_cnt=0 is a protocol error; the response is ignored.

## Timing
- Reset (reset low) values: id_valid=0, id_instr=0, id_pc=0, id_exc=0, im_req=0, pc_adv=0, all counters 0. Assertion takes effect without a clock.
- im_req, im_addr and pc_adv are combinational from pc, counters and flush. Queue outputs are registered state.
- Latency: grant at cycle t, rvalid at t+k (k≥1), id_valid at t+k+1.
- Bad-PC entry: allocated at cycle t, id_valid at t+1 if it is at the head.
- With DEPTH=4, 1-cycle memory and id_ready=1: one instruction per cycle steady state.
- After flush at cycle f: earliest new request at f+1 if drop_cnt<DEPTH. Stale responses are absorbed before any new response fills an entry (in-order memory guarantee).

## Test plan
- Reset release, pc stepping 0x3000, 0x3004, 0x3008; 1-cycle memory; id_ready=1. Expect first id_valid 2 cycles after first grant with id_pc=0x3000, then one instruction per cycle in order, id_exc=0.
- id_ready=0 for 10 cycles. Expect exactly 4 allocations, then pc_adv=0 and im_req=0. After release, 4 pops in order with no duplicate or missing PC, then fetching resumes.
- pc=0x3002, then pc=0x5000. Expect no im_req; two entries in order, each id_exc=4, id_instr=0, id_pc=0x3002 and 0x5000.
- 3-cycle memory, flush with 2 requests pending, pc then 0x4180. Expect drop_cnt=2, both late responses discarded, first id_valid carries id_pc=0x4180 with its own data.
- Flush in the same cycle as an im_rvalid with 1 pending. Expect drop_cnt stays 0 and that response is discarded.
- reset low mid-stream with 3 entries queued. Expect all outputs 0 before the next clock edge; after release, the first fetch starts from the supplied pc.
